// File: rtl/perceptron_core.sv
// perceptron_core
//   Two-stage pipelined 50-input dot product with 33-bit saturation.
//   Stage 1 registers the 50 full-precision 16x16 signed products.
//   Stage 2 sums the registered products at 38-bit precision, clamps the
//   result to the signed 33-bit range and registers it.
//   There is no handshake. A vector sampled at edge N is visible on
//   classification after edge N+1, and a new vector is accepted every cycle.
//
// Ports
//   clk                     rising-edge clock
//   rst                     synchronous active-high reset; clears both stages
//   input_0 .. input_49     signed 16-bit feature values x[i]
//   coeef_0 .. coeef_49     signed 16-bit weights w[i], paired with input_i
//   classification          signed 33-bit registered saturated weighted sum
module perceptron_core (
    input  logic signed        clk,
    input  logic signed        rst,
    input  logic signed [15:0] input_0,
    input  logic signed [15:0] input_1,
    input  logic signed [15:0] input_2,
    input  logic signed [15:0] input_3,
    input  logic signed [15:0] input_4,
    input  logic signed [15:0] input_5,
    input  logic signed [15:0] input_6,
    input  logic signed [15:0] input_7,
    input  logic signed [15:0] input_8,
    input  logic signed [15:0] input_9,
    input  logic signed [15:0] input_10,
    input  logic signed [15:0] input_11,
    input  logic signed [15:0] input_12,
    input  logic signed [15:0] input_13,
    input  logic signed [15:0] input_14,
    input  logic signed [15:0] input_15,
    input  logic signed [15:0] input_16,
    input  logic signed [15:0] input_17,
    input  logic signed [15:0] input_18,
    input  logic signed [15:0] input_19,
    input  logic signed [15:0] input_20,
    input  logic signed [15:0] input_21,
    input  logic signed [15:0] input_22,
    input  logic signed [15:0] input_23,
    input  logic signed [15:0] input_24,
    input  logic signed [15:0] input_25,
    input  logic signed [15:0] input_26,
    input  logic signed [15:0] input_27,
    input  logic signed [15:0] input_28,
    input  logic signed [15:0] input_29,
    input  logic signed [15:0] input_30,
    input  logic signed [15:0] input_31,
    input  logic signed [15:0] input_32,
    input  logic signed [15:0] input_33,
    input  logic signed [15:0] input_34,
    input  logic signed [15:0] input_35,
    input  logic signed [15:0] input_36,
    input  logic signed [15:0] input_37,
    input  logic signed [15:0] input_38,
    input  logic signed [15:0] input_39,
    input  logic signed [15:0] input_40,
    input  logic signed [15:0] input_41,
    input  logic signed [15:0] input_42,
    input  logic signed [15:0] input_43,
    input  logic signed [15:0] input_44,
    input  logic signed [15:0] input_45,
    input  logic signed [15:0] input_46,
    input  logic signed [15:0] input_47,
    input  logic signed [15:0] input_48,
    input  logic signed [15:0] input_49,
    input  logic signed [15:0] coeef_0,
    input  logic signed [15:0] coeef_1,
    input  logic signed [15:0] coeef_2,
    input  logic signed [15:0] coeef_3,
    input  logic signed [15:0] coeef_4,
    input  logic signed [15:0] coeef_5,
    input  logic signed [15:0] coeef_6,
    input  logic signed [15:0] coeef_7,
    input  logic signed [15:0] coeef_8,
    input  logic signed [15:0] coeef_9,
    input  logic signed [15:0] coeef_10,
    input  logic signed [15:0] coeef_11,
    input  logic signed [15:0] coeef_12,
    input  logic signed [15:0] coeef_13,
    input  logic signed [15:0] coeef_14,
    input  logic signed [15:0] coeef_15,
    input  logic signed [15:0] coeef_16,
    input  logic signed [15:0] coeef_17,
    input  logic signed [15:0] coeef_18,
    input  logic signed [15:0] coeef_19,
    input  logic signed [15:0] coeef_20,
    input  logic signed [15:0] coeef_21,
    input  logic signed [15:0] coeef_22,
    input  logic signed [15:0] coeef_23,
    input  logic signed [15:0] coeef_24,
    input  logic signed [15:0] coeef_25,
    input  logic signed [15:0] coeef_26,
    input  logic signed [15:0] coeef_27,
    input  logic signed [15:0] coeef_28,
    input  logic signed [15:0] coeef_29,
    input  logic signed [15:0] coeef_30,
    input  logic signed [15:0] coeef_31,
    input  logic signed [15:0] coeef_32,
    input  logic signed [15:0] coeef_33,
    input  logic signed [15:0] coeef_34,
    input  logic signed [15:0] coeef_35,
    input  logic signed [15:0] coeef_36,
    input  logic signed [15:0] coeef_37,
    input  logic signed [15:0] coeef_38,
    input  logic signed [15:0] coeef_39,
    input  logic signed [15:0] coeef_40,
    input  logic signed [15:0] coeef_41,
    input  logic signed [15:0] coeef_42,
    input  logic signed [15:0] coeef_43,
    input  logic signed [15:0] coeef_44,
    input  logic signed [15:0] coeef_45,
    input  logic signed [15:0] coeef_46,
    input  logic signed [15:0] coeef_47,
    input  logic signed [15:0] coeef_48,
    input  logic signed [15:0] coeef_49,
    output logic signed [32:0] classification
);

    localparam int N = 50;

    // Largest and smallest values representable in 33-bit two's complement.
    localparam logic signed [37:0] SUM_MAX = 38'sh00_FFFF_FFFF;
    localparam logic signed [37:0] SUM_MIN = -38'sh01_0000_0000;

    logic signed [15:0] x [N];
    logic signed [15:0] w [N];
    logic signed [31:0] prod [N];
    logic signed [37:0] sum;
    logic signed [32:0] sat_sum;

    // Gather the flat ports into arrays so the datapath can be written as loops.
    assign x[0]  = input_0;  assign x[1]  = input_1;  assign x[2]  = input_2;  assign x[3]  = input_3;  assign x[4]  = input_4;
    assign x[5]  = input_5;  assign x[6]  = input_6;  assign x[7]  = input_7;  assign x[8]  = input_8;  assign x[9]  = input_9;
    assign x[10] = input_10; assign x[11] = input_11; assign x[12] = input_12; assign x[13] = input_13; assign x[14] = input_14;
    assign x[15] = input_15; assign x[16] = input_16; assign x[17] = input_17; assign x[18] = input_18; assign x[19] = input_19;
    assign x[20] = input_20; assign x[21] = input_21; assign x[22] = input_22; assign x[23] = input_23; assign x[24] = input_24;
    assign x[25] = input_25; assign x[26] = input_26; assign x[27] = input_27; assign x[28] = input_28; assign x[29] = input_29;
    assign x[30] = input_30; assign x[31] = input_31; assign x[32] = input_32; assign x[33] = input_33; assign x[34] = input_34;
    assign x[35] = input_35; assign x[36] = input_36; assign x[37] = input_37; assign x[38] = input_38; assign x[39] = input_39;
    assign x[40] = input_40; assign x[41] = input_41; assign x[42] = input_42; assign x[43] = input_43; assign x[44] = input_44;
    assign x[45] = input_45; assign x[46] = input_46; assign x[47] = input_47; assign x[48] = input_48; assign x[49] = input_49;

    assign w[0]  = coeef_0;  assign w[1]  = coeef_1;  assign w[2]  = coeef_2;  assign w[3]  = coeef_3;  assign w[4]  = coeef_4;
    assign w[5]  = coeef_5;  assign w[6]  = coeef_6;  assign w[7]  = coeef_7;  assign w[8]  = coeef_8;  assign w[9]  = coeef_9;
    assign w[10] = coeef_10; assign w[11] = coeef_11; assign w[12] = coeef_12; assign w[13] = coeef_13; assign w[14] = coeef_14;
    assign w[15] = coeef_15; assign w[16] = coeef_16; assign w[17] = coeef_17; assign w[18] = coeef_18; assign w[19] = coeef_19;
    assign w[20] = coeef_20; assign w[21] = coeef_21; assign w[22] = coeef_22; assign w[23] = coeef_23; assign w[24] = coeef_24;
    assign w[25] = coeef_25; assign w[26] = coeef_26; assign w[27] = coeef_27; assign w[28] = coeef_28; assign w[29] = coeef_29;
    assign w[30] = coeef_30; assign w[31] = coeef_31; assign w[32] = coeef_32; assign w[33] = coeef_33; assign w[34] = coeef_34;
    assign w[35] = coeef_35; assign w[36] = coeef_36; assign w[37] = coeef_37; assign w[38] = coeef_38; assign w[39] = coeef_39;
    assign w[40] = coeef_40; assign w[41] = coeef_41; assign w[42] = coeef_42; assign w[43] = coeef_43; assign w[44] = coeef_44;
    assign w[45] = coeef_45; assign w[46] = coeef_46; assign w[47] = coeef_47; assign w[48] = coeef_48; assign w[49] = coeef_49;

    // Stage 1: full-precision products. -32768 * -32768 = 2^30 still fits in 32 bits.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                prod[i] <= '0;
            end else begin
                prod[i] <= x[i] * w[i];
            end
        end
    end

    // 50 products of magnitude <= 2^30 need at most 37 bits; 38 leaves margin.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + {{6{prod[i][31]}}, prod[i]};
        end
    end

    always_comb begin
        sat_sum = sum[32:0];
        if (sum > SUM_MAX) begin
            sat_sum = SUM_MAX[32:0];
        end else if (sum < SUM_MIN) begin
            sat_sum = SUM_MIN[32:0];
        end
    end

    // Stage 2: registered saturated sum; rst clears it together with stage 1
    // so no pre-reset vector can surface afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            classification <= '0;
        end else begin
            classification <= sat_sum;
        end
    end

endmodule

// File: tb/tb_perceptron_core.sv
module tb_perceptron_core;

  localparam int N = 50;

  logic signed        clk;
  logic signed        rst;
  logic signed [15:0] x [N];
  logic signed [15:0] w [N];
  logic signed [32:0] classification;

  // staged vector: the driver copies it onto the pins at the falling edge
  logic signed [15:0] sx [N];
  logic signed [15:0] sw [N];

  // scoreboard
  logic [32:0] exp_q[$];
  int          n_checks;
  int          n_errors;
  int          cyc;

  // reference state: what was sampled at the previous edge
  longint      prev_dot;
  logic        prev_rst;

  perceptron_core dut (
    .clk(clk), .rst(rst),
    .input_0(x[0]), .input_1(x[1]), .input_2(x[2]), .input_3(x[3]), .input_4(x[4]),
    .input_5(x[5]), .input_6(x[6]), .input_7(x[7]), .input_8(x[8]), .input_9(x[9]),
    .input_10(x[10]), .input_11(x[11]), .input_12(x[12]), .input_13(x[13]), .input_14(x[14]),
    .input_15(x[15]), .input_16(x[16]), .input_17(x[17]), .input_18(x[18]), .input_19(x[19]),
    .input_20(x[20]), .input_21(x[21]), .input_22(x[22]), .input_23(x[23]), .input_24(x[24]),
    .input_25(x[25]), .input_26(x[26]), .input_27(x[27]), .input_28(x[28]), .input_29(x[29]),
    .input_30(x[30]), .input_31(x[31]), .input_32(x[32]), .input_33(x[33]), .input_34(x[34]),
    .input_35(x[35]), .input_36(x[36]), .input_37(x[37]), .input_38(x[38]), .input_39(x[39]),
    .input_40(x[40]), .input_41(x[41]), .input_42(x[42]), .input_43(x[43]), .input_44(x[44]),
    .input_45(x[45]), .input_46(x[46]), .input_47(x[47]), .input_48(x[48]), .input_49(x[49]),
    .coeef_0(w[0]), .coeef_1(w[1]), .coeef_2(w[2]), .coeef_3(w[3]), .coeef_4(w[4]),
    .coeef_5(w[5]), .coeef_6(w[6]), .coeef_7(w[7]), .coeef_8(w[8]), .coeef_9(w[9]),
    .coeef_10(w[10]), .coeef_11(w[11]), .coeef_12(w[12]), .coeef_13(w[13]), .coeef_14(w[14]),
    .coeef_15(w[15]), .coeef_16(w[16]), .coeef_17(w[17]), .coeef_18(w[18]), .coeef_19(w[19]),
    .coeef_20(w[20]), .coeef_21(w[21]), .coeef_22(w[22]), .coeef_23(w[23]), .coeef_24(w[24]),
    .coeef_25(w[25]), .coeef_26(w[26]), .coeef_27(w[27]), .coeef_28(w[28]), .coeef_29(w[29]),
    .coeef_30(w[30]), .coeef_31(w[31]), .coeef_32(w[32]), .coeef_33(w[33]), .coeef_34(w[34]),
    .coeef_35(w[35]), .coeef_36(w[36]), .coeef_37(w[37]), .coeef_38(w[38]), .coeef_39(w[39]),
    .coeef_40(w[40]), .coeef_41(w[41]), .coeef_42(w[42]), .coeef_43(w[43]), .coeef_44(w[44]),
    .coeef_45(w[45]), .coeef_46(w[46]), .coeef_47(w[47]), .coeef_48(w[48]), .coeef_49(w[49]),
    .classification(classification)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      x[i] = '0;
      w[i] = '0;
      sx[i] = '0;
      sw[i] = '0;
    end
  end

  // reference model: exact dot product in 64-bit arithmetic, then clamp
  function automatic longint dot_staged();
    longint acc;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      acc = acc + longint'(sx[i]) * longint'(sw[i]);
    end
    return acc;
  endfunction

  function automatic logic [32:0] sat33(input longint s);
    longint c;
    c = s;
    if (c > 64'sd4294967295) c = 64'sd4294967295;
    if (c < -64'sd4294967296) c = -64'sd4294967296;
    return c[32:0];
  endfunction

  // driver tasks
  task automatic stage_fill(input int xv, input int wv);
    for (int i = 0; i < N; i++) begin
      sx[i] = 16'(xv);
      sw[i] = 16'(wv);
    end
  endtask

  task automatic stage_random(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin
          sx[i] = 16'($urandom());
          sw[i] = 16'($urandom());
        end
        1: begin
          sx[i] = 16'($urandom_range(0, 200)) - 16'sd100;
          sw[i] = 16'($urandom_range(0, 200)) - 16'sd100;
        end
        2: begin
          sx[i] = 16'($urandom_range(32000, 32767));
          sw[i] = 16'($urandom_range(32000, 32767));
        end
        default: begin
          sx[i] = -16'sd32768 + 16'($urandom_range(0, 500));
          sw[i] = 16'($urandom_range(32000, 32767));
        end
      endcase
    end
  endtask

  // Applies the staged vector and rst at the falling edge, and queues what
  // classification must show after the next rising edge: the clamped dot
  // product of the vector sampled one edge earlier, or 0 if rst was high at
  // either of those two edges.
  task automatic drive(input logic r);
    longint cur_dot;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < N; i++) begin
      x[i] = sx[i];
      w[i] = sw[i];
    end
    cur_dot = dot_staged();
    if (r || prev_rst) exp_q.push_back(33'd0);
    else               exp_q.push_back(sat33(prev_dot));
    prev_dot = cur_dot;
    prev_rst = r;
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) drive(1'b0);
  endtask

  // monitor: pops one expectation per rising edge once the stream has started
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (classification !== e) begin
          n_errors++;
          $display("FAIL classification cyc=%0d got=%0d exp=%0d",
                   cyc, classification, $signed(e));
        end
      end
    end
  end

  // stimulus
  initial begin
    n_checks = 0;
    n_errors = 0;
    prev_dot = 0;
    prev_rst = 1'b1;

    // reset, then the 55 vector held
    stage_fill(0, 0);
    drive(1'b1);
    drive(1'b1);
    stage_fill(1, 1);
    sx[0] = 16'sd3;
    sw[0] = 16'sd2;
    hold(4);

    // zeros and sign check
    stage_fill(0, 0);
    hold(2);
    sx[0] = -16'sd3;
    sw[0] = 16'sd2;
    hold(2);

    // positive and negative saturation
    stage_fill(32767, 32767);
    hold(3);
    stage_fill(-32768, 32767);
    hold(3);

    // A, B, C back to back
    stage_fill(1, 1); sx[0] = 16'sd3; sw[0] = 16'sd2;
    drive(1'b0);
    stage_fill(0, 0); sx[0] = -16'sd3; sw[0] = 16'sd2;
    drive(1'b0);
    stage_fill(0, 0);
    drive(1'b0);
    hold(1);

    // A in flight when rst pulses for one cycle; then a saturating vector
    stage_fill(1, 1); sx[0] = 16'sd3; sw[0] = 16'sd2;
    drive(1'b0);
    stage_fill(32767, 32767);
    drive(1'b1);
    hold(3);

    // randomized stream with occasional resets
    for (int k = 0; k < 400; k++) begin
      stage_random(int'($urandom_range(0, 3)));
      drive($urandom_range(0, 24) == 0);
    end
    hold(2);

    // the monitor must have consumed every expectation
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // hard stop in case anything stalls
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
